wb_skid_stage: RTL and testbench

Parametrised MEM/WB pipeline stage for the vector processor, replacing the fixed 8-lane, always-advancing register with a valid/ready stage backed by a one-entry skid buffer. It carries the scalar writeback (register-write enable, address, selected writeback data) and an N-lane vector result with a per-lane write mask. It sits between the memory stage and the scalar and vector register files. It supports downstream back-pressure, pipeline flush, and suppression of writes to the hard-wired zero register.

---
 rtl/wb_skid_stage.sv | 162 ++++++++++++++++
 tb/tb_wb_skid_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_skid_stage.sv
// MEM/WB stage: valid/ready handshake with a one-entry skid buffer.
// Carries scalar writeback plus an N-lane masked vector result.
module wb_skid_stage #(
    parameter int DATA_W            = 32,
    parameter int NUM_LANES         = 8,
    parameter int ADDR_W            = 5,
    parameter int ZERO_REG_SUPPRESS = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic                        reg_write_i,
    input  logic                        mem_to_reg_i,
    input  logic [DATA_W-1:0]           alu_result_i,
    input  logic [DATA_W-1:0]           read_data_i,
    input  logic [ADDR_W-1:0]           write_addr_i,
    input  logic                        vreg_write_i,
    input  logic [NUM_LANES-1:0]        lane_mask_i,
    input  logic [NUM_LANES*DATA_W-1:0] valu_result_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic                        reg_write_o,
    output logic [DATA_W-1:0]           wb_data_o,
    output logic [ADDR_W-1:0]           write_addr_o,
    output logic                        vreg_write_o,
    output logic [NUM_LANES-1:0]        lane_mask_o,
    output logic [NUM_LANES*DATA_W-1:0] valu_result_o
);

    localparam int VW = NUM_LANES * DATA_W;

    // main (m_*) register drives the outputs, skid (s_*) absorbs one stall
    logic                 m_valid, s_valid;
    logic                 m_rw, s_rw;
    logic [DATA_W-1:0]    m_wb, s_wb;
    logic [ADDR_W-1:0]    m_addr, s_addr;
    logic                 m_vreg, s_vreg;
    logic [NUM_LANES-1:0] m_mask, s_mask;
    logic [VW-1:0]        m_valu, s_valu;

    logic                 cap_rw;
    logic [DATA_W-1:0]    cap_wb;
    logic [VW-1:0]        cap_valu;

    logic accept, issue;
    logic ld_m_in, ld_m_s, ld_s;
    logic m_valid_nxt, s_valid_nxt;

    assign in_ready_o = !s_valid;
    assign accept     = in_valid_i & in_ready_o;
    assign issue      = m_valid & out_ready_i;

    // capture transform: writeback mux, zero-register drop, lane zeroing
    always_comb begin
        cap_wb   = mem_to_reg_i ? read_data_i : alu_result_i;
        cap_rw   = reg_write_i &
                   !((ZERO_REG_SUPPRESS != 0) && (write_addr_i == '0));
        cap_valu = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (lane_mask_i[k]) begin
                cap_valu[k*DATA_W +: DATA_W] = valu_result_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // occupancy control: decide which register loads and the next valid bits
    always_comb begin
        ld_m_in     = 1'b0;
        ld_m_s      = 1'b0;
        ld_s        = 1'b0;
        m_valid_nxt = m_valid;
        s_valid_nxt = s_valid;
        if (flush_i) begin
            m_valid_nxt = 1'b0;
            s_valid_nxt = 1'b0;
        end else if (!m_valid) begin
            if (accept) begin
                ld_m_in     = 1'b1;
                m_valid_nxt = 1'b1;
            end
        end else if (issue && s_valid) begin
            ld_m_s      = 1'b1;
            s_valid_nxt = 1'b0;
        end else if (issue) begin
            if (accept) begin
                ld_m_in = 1'b1;
            end else begin
                m_valid_nxt = 1'b0;
            end
        end else if (accept) begin
            ld_s        = 1'b1;
            s_valid_nxt = 1'b1;
        end
    end

    // valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else begin
            m_valid <= m_valid_nxt;
            s_valid <= s_valid_nxt;
        end
    end

    // main payload: loads from the input or drains the skid entry
    always_ff @(posedge clk) begin
        if (rst) begin
            m_rw   <= 1'b0;
            m_wb   <= '0;
            m_addr <= '0;
            m_vreg <= 1'b0;
            m_mask <= '0;
            m_valu <= '0;
        end else if (ld_m_in) begin
            m_rw   <= cap_rw;
            m_wb   <= cap_wb;
            m_addr <= write_addr_i;
            m_vreg <= vreg_write_i;
            m_mask <= lane_mask_i;
            m_valu <= cap_valu;
        end else if (ld_m_s) begin
            m_rw   <= s_rw;
            m_wb   <= s_wb;
            m_addr <= s_addr;
            m_vreg <= s_vreg;
            m_mask <= s_mask;
            m_valu <= s_valu;
        end
    end

    // skid payload: absorbs the entry accepted while the output stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s_rw   <= 1'b0;
            s_wb   <= '0;
            s_addr <= '0;
            s_vreg <= 1'b0;
            s_mask <= '0;
            s_valu <= '0;
        end else if (ld_s) begin
            s_rw   <= cap_rw;
            s_wb   <= cap_wb;
            s_addr <= write_addr_i;
            s_vreg <= vreg_write_i;
            s_mask <= lane_mask_i;
            s_valu <= cap_valu;
        end
    end

    assign out_valid_o   = m_valid;
    assign reg_write_o   = m_rw & m_valid;
    assign vreg_write_o  = m_vreg & m_valid;
    assign lane_mask_o   = m_mask & {NUM_LANES{m_valid}};
    assign wb_data_o     = m_wb;
    assign write_addr_o  = m_addr;
    assign valu_result_o = m_valu;

endmodule

// File: tb/tb_wb_skid_stage.sv
// Bench for wb_skid_stage: queue model of a two-deep FIFO stage,
// per-cycle compare, directed literal checks, then random traffic.
module tb_wb_skid_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic         reg_write_i;
    logic         mem_to_reg_i;
    logic [31:0]  alu_result_i;
    logic [31:0]  read_data_i;
    logic [4:0]   write_addr_i;
    logic         vreg_write_i;
    logic [7:0]   lane_mask_i;
    logic [255:0] valu_result_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic         reg_write_o;
    logic [31:0]  wb_data_o;
    logic [4:0]   write_addr_o;
    logic         vreg_write_o;
    logic [7:0]   lane_mask_o;
    logic [255:0] valu_result_o;

    wb_skid_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .reg_write_i   (reg_write_i),
        .mem_to_reg_i  (mem_to_reg_i),
        .alu_result_i  (alu_result_i),
        .read_data_i   (read_data_i),
        .write_addr_i  (write_addr_i),
        .vreg_write_i  (vreg_write_i),
        .lane_mask_i   (lane_mask_i),
        .valu_result_i (valu_result_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .reg_write_o   (reg_write_o),
        .wb_data_o     (wb_data_o),
        .write_addr_o  (write_addr_o),
        .vreg_write_o  (vreg_write_o),
        .lane_mask_o   (lane_mask_o),
        .valu_result_o (valu_result_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         rw;
        logic [31:0]  wb;
        logic [4:0]   addr;
        logic         vreg;
        logic [7:0]   mask;
        logic [255:0] valu;
    } ent_t;

    ent_t q[$];
    ent_t last;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic ent_t xform();
        ent_t e;
        e.wb   = mem_to_reg_i ? read_data_i : alu_result_i;
        e.rw   = reg_write_i && (write_addr_i != 5'd0);
        e.addr = write_addr_i;
        e.vreg = vreg_write_i;
        e.mask = lane_mask_i;
        for (int k = 0; k < 8; k++)
            e.valu[k*32 +: 32] = lane_mask_i[k] ? valu_result_i[k*32 +: 32] : 32'h0;
        return e;
    endfunction

    // model: the stage behaves as a FIFO holding at most two entries
    always @(posedge clk) begin
        bit acc, iss;
        if (rst) begin
            q.delete();
            last = '0;
        end else if (flush_i) begin
            q.delete();
        end else begin
            acc = in_valid_i && (q.size() < 2);
            iss = (q.size() > 0) && out_ready_i;
            if (iss) void'(q.pop_front());
            if (acc) q.push_back(xform());
        end
        if (q.size() > 0) last = q[0];
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            bit v;
            v = q.size() > 0;
            chk("out_valid", 256'(out_valid_o), 256'(v));
            chk("in_ready", 256'(in_ready_o), 256'(q.size() < 2));
            chk("reg_write", 256'(reg_write_o), 256'(last.rw & v));
            chk("vreg_write", 256'(vreg_write_o), 256'(last.vreg & v));
            chk("lane_mask", 256'(lane_mask_o), 256'(v ? last.mask : 8'h0));
            chk("wb_data", 256'(wb_data_o), 256'(last.wb));
            chk("write_addr", 256'(write_addr_o), 256'(last.addr));
            chk("valu", valu_result_o, last.valu);
        end
    end

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] rd,
                         input logic [4:0] addr, input logic vw,
                         input logic [7:0] mask, input logic [255:0] valu);
        in_valid_i    = v;
        reg_write_i   = rw;
        mem_to_reg_i  = m2r;
        alu_result_i  = alu;
        read_data_i   = rd;
        write_addr_i  = addr;
        vreg_write_i  = vw;
        lane_mask_i   = mask;
        valu_result_i = valu;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic fill_both(input logic [31:0] a, input logic [31:0] b);
        out_ready_i = 0;
        drive(1, 1, 0, a, 0, 5'd7, 1, 8'hFF, {8{a}});
        @(negedge clk);
        drive(1, 1, 0, b, 0, 5'd8, 1, 8'hFF, {8{b}});
        @(negedge clk);
        chk("fill_in_ready", 256'(in_ready_o), 256'(0));
        chk("fill_head", 256'(wb_data_o), 256'(a));
    endtask

    logic [255:0] exp_lanes;
    logic [255:0] rv;

    initial begin
        rst = 1; flush_i = 0; out_ready_i = 1;
        idle();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk_en = 1;
        chk("rst_in_ready", 256'(in_ready_o), 256'(1));
        chk("rst_out_valid", 256'(out_valid_o), 256'(0));
        chk("rst_wb", 256'(wb_data_o), 256'(0));
        chk("rst_valu", valu_result_o, 256'(0));

        // stream 1..4 with one-cycle latency
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, 0, 32'(i), 32'h55, 5'd2, 0, 0, '0);
            @(negedge clk);
            chk("stream_valid", 256'(out_valid_o), 256'(1));
            chk("stream_wb", 256'(wb_data_o), 256'(i));
        end
        idle();
        @(negedge clk);

        // writeback mux and zero-register suppression
        drive(1, 1, 1, 32'h1234, 32'hDEADBEEF, 5'd0, 0, 0, '0);
        @(negedge clk);
        chk("mux_wb", 256'(wb_data_o), 256'h0DEADBEEF);
        chk("zero_suppress", 256'(reg_write_o), 256'(0));
        drive(1, 1, 0, 32'h77, 32'h0, 5'd3, 0, 0, '0);
        @(negedge clk);
        chk("addr3_rw", 256'(reg_write_o), 256'(1));
        chk("addr3_addr", 256'(write_addr_o), 256'(3));
        idle();
        @(negedge clk);

        // lane mask 0xA5: lanes 1,3,4,6 zeroed
        drive(1, 0, 0, 0, 0, 5'd1, 1, 8'hA5, {8{32'hFFFFFFFF}});
        @(negedge clk);
        exp_lanes = {32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0,
                     32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
        chk("mask_out", 256'(lane_mask_o), 256'hA5);
        chk("mask_lanes", valu_result_o, exp_lanes);
        chk("mask_vreg", 256'(vreg_write_o), 256'(1));
        idle();
        @(negedge clk);
        @(negedge clk);

        // back-pressure: A,B,C,D
        out_ready_i = 0;
        drive(1, 1, 0, 32'hA, 0, 5'd4, 0, 0, '0);
        @(negedge clk);
        chk("bp_a_out", 256'(wb_data_o), 256'hA);
        chk("bp_ready1", 256'(in_ready_o), 256'(1));
        drive(1, 1, 0, 32'hB, 0, 5'd4, 0, 0, '0);
        @(negedge clk);
        chk("bp_ready_fall", 256'(in_ready_o), 256'(0));
        chk("bp_a_hold", 256'(wb_data_o), 256'hA);
        drive(1, 1, 0, 32'hC, 0, 5'd4, 0, 0, '0);
        @(negedge clk);
        chk("bp_ready_low", 256'(in_ready_o), 256'(0));
        out_ready_i = 1;
        @(negedge clk);
        chk("bp_b_out", 256'(wb_data_o), 256'hB);
        chk("bp_ready_rise", 256'(in_ready_o), 256'(1));
        @(negedge clk);
        chk("bp_c_out", 256'(wb_data_o), 256'hC);
        drive(1, 1, 0, 32'hD, 0, 5'd4, 0, 0, '0);
        @(negedge clk);
        chk("bp_d_out", 256'(wb_data_o), 256'hD);
        idle();
        @(negedge clk);
        chk("bp_drained", 256'(out_valid_o), 256'(0));

        // flush with both registers full and an entry offered
        fill_both(32'hE0, 32'hF0);
        drive(1, 1, 0, 32'h66, 0, 5'd9, 1, 8'hFF, {8{32'h66}});
        flush_i = 1;
        @(negedge clk);
        flush_i = 0;
        idle();
        out_ready_i = 1;
        chk("flush_valid", 256'(out_valid_o), 256'(0));
        chk("flush_rw", 256'(reg_write_o), 256'(0));
        chk("flush_mask", 256'(lane_mask_o), 256'(0));
        chk("flush_ready", 256'(in_ready_o), 256'(1));
        @(negedge clk);
        chk("flush_empty", 256'(out_valid_o), 256'(0));

        // reset mid-stall
        fill_both(32'h11, 32'h22);
        rst = 1;
        @(negedge clk);
        rst = 0;
        idle();
        out_ready_i = 1;
        chk("rst2_ready", 256'(in_ready_o), 256'(1));
        chk("rst2_valid", 256'(out_valid_o), 256'(0));
        chk("rst2_wb", 256'(wb_data_o), 256'(0));
        chk("rst2_addr", 256'(write_addr_o), 256'(0));
        chk("rst2_mask", 256'(lane_mask_o), 256'(0));
        chk("rst2_valu", valu_result_o, 256'(0));

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 8; k++) rv[k*32 +: 32] = $urandom;
            drive(($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom),
                  $urandom, $urandom, 5'($urandom_range(0, 3)),
                  1'($urandom), 8'($urandom), rv);
            out_ready_i = ($urandom_range(0, 9) < 6);
            flush_i     = ($urandom_range(0, 31) == 0);
            rst         = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst = 0; flush_i = 0;
        idle();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
